fb_write_arbiter: RTL

- Owns the framebuffer write port (we/addr/din) on the CPU clock domain and shares it between two requesters: CPU single-pixel stores and an internal rectangle-fill engine.
- Sits between the CPU MMIO decode and the framebuffer's arb_* port; the DVI controller read side is untouched.
- Arbitration is round-robin, so a long fill never starves the CPU and the CPU never starves a fill.

---
 rtl/fb_pkg.sv | 11 +
 rtl/fb_rect_walker.sv | 73 +++++++
 rtl/fb_write_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, port widths and fill FSM state encoding shared by the write arbiter
package fb_pkg;
    localparam int H_RES    = 1024;
    localparam int V_RES    = 768;
    localparam int FB_DEPTH = H_RES * V_RES;
    localparam int ADDR_W   = 20;
    localparam int DATA_W   = 1;
    localparam int X_W      = 11;
    localparam int Y_W      = 10;
    typedef enum logic [1:0] {IDLE, CLIP, RUN, DONE} fill_state_t;
endpackage

// File: rtl/fb_rect_walker.sv
// fb_rect_walker: clips a latched rectangle to the screen and walks its pixel addresses one grant at a time
module fb_rect_walker
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clip,
    input  logic              run,
    input  logic              abort,
    input  logic [X_W-1:0]    x0,
    input  logic [X_W-1:0]    w,
    input  logic [Y_W-1:0]    y0,
    input  logic [Y_W-1:0]    h,
    input  logic              grant,
    output logic              empty,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam logic [X_W:0] X_LIM  = (X_W + 1)'(H_RES);
    localparam logic [Y_W:0] Y_LIM  = (Y_W + 1)'(V_RES);
    localparam bit           H_POW2 = (H_RES & (H_RES - 1)) == 0;
    logic [X_W-1:0]    x0_q, x0_d, w_q, w_d, cur_x_q, cur_x_d;
    logic [Y_W-1:0]    y0_q, y0_d, h_q, h_d, cur_y_q, cur_y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, y0_base;
    logic [X_W:0]      x_sum, x_end, x_nxt;
    logic [Y_W:0]      y_sum, y_end, y_nxt;
    logic              row_end;

    // sums carry one extra bit so an oversized w/h clips instead of wrapping
    always_comb begin
        x_sum      = {1'b0, x0_q} + {1'b0, w_q};
        y_sum      = {1'b0, y0_q} + {1'b0, h_q};
        x_end      = (x_sum > X_LIM) ? X_LIM : x_sum;
        y_end      = (y_sum > Y_LIM) ? Y_LIM : y_sum;
        x_nxt      = {1'b0, cur_x_q} + 1'b1;
        y_nxt      = {1'b0, cur_y_q} + 1'b1;
        row_end    = x_nxt == x_end;
        last       = row_end && (y_nxt == y_end);
        empty      = ({1'b0, x0_q} >= X_LIM) || ({1'b0, y0_q} >= Y_LIM) || (w_q == '0) || (h_q == '0);
        req        = run && !abort;
        addr       = row_base_q + ADDR_W'(cur_x_q);
        y0_base    = H_POW2 ? (ADDR_W'(y0_q) << $clog2(H_RES)) : (ADDR_W'(y0_q) * ADDR_W'(H_RES));
        x0_d       = load ? x0 : x0_q;
        w_d        = load ? w : w_q;
        y0_d       = load ? y0 : y0_q;
        h_d        = load ? h : h_q;
        cur_x_d    = clip ? x0_q : grant ? (row_end ? x0_q : x_nxt[X_W-1:0]) : cur_x_q;
        cur_y_d    = clip ? y0_q : (grant && row_end) ? y_nxt[Y_W-1:0] : cur_y_q;
        row_base_d = clip ? y0_base : (grant && row_end) ? row_base_q + ADDR_W'(H_RES) : row_base_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q       <= '0;
            w_q        <= '0;
            y0_q       <= '0;
            h_q        <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            row_base_q <= '0;
        end else begin
            x0_q       <= x0_d;
            w_q        <= w_d;
            y0_q       <= y0_d;
            h_q        <= h_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            row_base_q <= row_base_d;
        end
    end
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin owner of the framebuffer write port, shared by CPU pixel stores and the rectangle-fill engine
module fb_write_arbiter
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic              cpu_ack,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [X_W-1:0]    fill_x0,
    input  logic [X_W-1:0]    fill_w,
    input  logic [Y_W-1:0]    fill_y0,
    input  logic [Y_W-1:0]    fill_h,
    input  logic [DATA_W-1:0] fill_color,
    input  logic              fill_abort,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_din
);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(FB_DEPTH);
    fill_state_t       state_q, state_d;
    logic              fill_ready_q, fill_busy_q, fill_done_q;
    logic              cpu_ack_q, cpu_ack_d, fb_we_q, fb_we_d, last_cpu_q, last_cpu_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d, walk_addr;
    logic [DATA_W-1:0] fb_din_q, fb_din_d, color_q, color_d;
    logic              accept, cpu_elig, fill_req, grant_cpu, grant_fill, walk_empty, walk_last;

    fb_rect_walker u_walker (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .clip  (state_q == CLIP),
        .run   (state_q == RUN),
        .abort (fill_abort),
        .x0    (fill_x0),
        .w     (fill_w),
        .y0    (fill_y0),
        .h     (fill_h),
        .grant (grant_fill),
        .empty (walk_empty),
        .req   (fill_req),
        .addr  (walk_addr),
        .last  (walk_last)
    );

    // last_cpu_q records who was granted last; the other side wins a tie
    always_comb begin
        accept     = fill_valid && fill_ready_q;
        cpu_elig   = cpu_req && !cpu_ack_q;
        grant_cpu  = cpu_elig && (!fill_req || !last_cpu_q);
        grant_fill = fill_req && !grant_cpu;
        last_cpu_d = grant_cpu ? 1'b1 : grant_fill ? 1'b0 : last_cpu_q;
        color_d    = accept ? fill_color : color_q;
        state_d    = (state_q == IDLE) ? (accept ? CLIP : IDLE)
                   : (state_q == CLIP) ? ((fill_abort || walk_empty) ? DONE : RUN)
                   : (state_q == RUN)  ? ((fill_abort || (grant_fill && walk_last)) ? DONE : RUN)
                   : IDLE;
        cpu_ack_d  = grant_cpu;
        fb_we_d    = grant_fill || (grant_cpu && (cpu_addr < DEPTH_A));
        fb_addr_d  = grant_cpu ? cpu_addr : grant_fill ? walk_addr : fb_addr_q;
        fb_din_d   = grant_cpu ? cpu_din : grant_fill ? color_q : fb_din_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fill_ready_q <= 1'b1;
            fill_busy_q  <= 1'b0;
            fill_done_q  <= 1'b0;
            last_cpu_q   <= 1'b1;
            color_q      <= '0;
            cpu_ack_q    <= 1'b0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_din_q     <= '0;
        end else begin
            state_q      <= state_d;
            fill_ready_q <= state_d == IDLE;
            fill_busy_q  <= state_d != IDLE;
            fill_done_q  <= state_d == DONE;
            last_cpu_q   <= last_cpu_d;
            color_q      <= color_d;
            cpu_ack_q    <= cpu_ack_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_din_q     <= fb_din_d;
        end
    end

    assign fill_ready = fill_ready_q;
    assign fill_busy  = fill_busy_q;
    assign fill_done  = fill_done_q;
    assign cpu_ack    = cpu_ack_q;
    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_din     = fb_din_q;
endmodule
